// File: rtl/stg1if_if.sv
// Instruction-fetch stage bus: the beat from the instruction-address stage
// (pc + memory word) and the registered beat handed to decode.
interface stg1if_if #(
  parameter int ADDR_W  = 24,
  parameter int INSTR_W = 24
);
  logic [ADDR_W-1:0]  iw_pc;
  logic               iw_ia_valid;
  logic [INSTR_W-1:0] iw_mem_data;
  logic               iw_stall;
  logic               iw_flush;
  logic [ADDR_W-1:0]  ow_pc;
  logic [INSTR_W-1:0] ow_instr;
  logic               ow_if_valid;
  logic               ow_hold;

  // Handshake: a beat moves upstream->stage when iw_ia_valid=1 and ow_hold=0
  // (and no flush); it moves stage->downstream when ow_if_valid=1 and
  // iw_stall=0. While ow_hold=1 upstream must keep re-presenting its beat.
  modport master (
    output iw_pc, iw_ia_valid, iw_mem_data, iw_stall, iw_flush,
    input  ow_pc, ow_instr, ow_if_valid, ow_hold
  );

  modport slave (
    input  iw_pc, iw_ia_valid, iw_mem_data, iw_stall, iw_flush,
    output ow_pc, ow_instr, ow_if_valid, ow_hold
  );
endinterface

// File: rtl/stg1if.sv
// Instruction-fetch register stage: an output register backed by a one-entry
// skid buffer so the registered ow_hold can lag the downstream stall by a cycle.
module stg1if_core #(
  parameter int ADDR_W  = 24,
  parameter int INSTR_W = 24
) (
  input  logic         clk,
  input  logic         rst,
  stg1if_if.slave      bus,
  output logic [1:0]   dbg_state
);
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]  skd_pc_q, skd_pc_d;
  logic [INSTR_W-1:0] skd_instr_q, skd_instr_d;

  logic out_vld;
  logic hold;
  logic accept;
  logic take;

  // Entry valid bits are decoded from the state register, so OUT.valid and
  // SKD.valid are registered and ow_hold has no path from any input.
  always_comb begin
    out_vld = (state_q != ST_EMPTY);
    hold    = (state_q == ST_FULL);
    accept  = bus.iw_ia_valid & ~hold & ~bus.iw_flush;
    take    = out_vld & ~bus.iw_stall;
  end

  always_comb begin
    state_d     = state_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    skd_pc_d    = skd_pc_q;
    skd_instr_d = skd_instr_q;
    if (bus.iw_flush) begin
      // Payload is left stale; only the valid bits (the state) clear.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_pc_d    = bus.iw_pc;
            out_instr_d = bus.iw_mem_data;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && take) begin
            out_pc_d    = bus.iw_pc;
            out_instr_d = bus.iw_mem_data;
          end else if (accept) begin
            skd_pc_d    = bus.iw_pc;
            skd_instr_d = bus.iw_mem_data;
            state_d     = ST_FULL;
          end else if (take) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (take) begin
            out_pc_d    = skd_pc_q;
            out_instr_d = skd_instr_q;
            state_d     = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      skd_pc_q    <= '0;
      skd_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      skd_pc_q    <= skd_pc_d;
      skd_instr_q <= skd_instr_d;
    end
  end

  assign bus.ow_pc       = out_pc_q;
  assign bus.ow_instr    = out_instr_q;
  assign bus.ow_if_valid = out_vld;
  assign bus.ow_hold     = hold;
  assign dbg_state       = state_q;
endmodule

module stg1if #(
  parameter int ADDR_W  = 24,
  parameter int INSTR_W = 24
) (
  input  logic               iw_clk,
  input  logic               iw_rst,
  input  logic [ADDR_W-1:0]  iw_pc,
  input  logic               iw_ia_valid,
  input  logic [INSTR_W-1:0] iw_mem_data,
  input  logic               iw_stall,
  input  logic               iw_flush,
  output logic [ADDR_W-1:0]  ow_pc,
  output logic [INSTR_W-1:0] ow_instr,
  output logic               ow_if_valid,
  output logic               ow_hold,
  output logic [1:0]         ow_dbg_state
);
  stg1if_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_bus ();

  assign u_bus.iw_pc       = iw_pc;
  assign u_bus.iw_ia_valid = iw_ia_valid;
  assign u_bus.iw_mem_data = iw_mem_data;
  assign u_bus.iw_stall    = iw_stall;
  assign u_bus.iw_flush    = iw_flush;
  assign ow_pc             = u_bus.ow_pc;
  assign ow_instr          = u_bus.ow_instr;
  assign ow_if_valid       = u_bus.ow_if_valid;
  assign ow_hold           = u_bus.ow_hold;

  stg1if_core #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_core (
    .clk       (iw_clk),
    .rst       (iw_rst),
    .bus       (u_bus.slave),
    .dbg_state (ow_dbg_state)
  );
endmodule

// File: tb/tb_stg1if.sv
// Bench for stg1if: directed vector table for the documented scenarios, then
// random traffic checked against a two-deep in-order queue model.
module tb_stg1if;
  localparam int W = 24;

  logic         clk;
  logic         rst;
  logic [1:0]   dbg_state;
  int           total;
  int           bad;

  stg1if_if #(.ADDR_W(W), .INSTR_W(W)) bus ();

  stg1if #(.ADDR_W(W), .INSTR_W(W)) dut (
    .iw_clk       (clk),
    .iw_rst       (rst),
    .iw_pc        (bus.iw_pc),
    .iw_ia_valid  (bus.iw_ia_valid),
    .iw_mem_data  (bus.iw_mem_data),
    .iw_stall     (bus.iw_stall),
    .iw_flush     (bus.iw_flush),
    .ow_pc        (bus.ow_pc),
    .ow_instr     (bus.ow_instr),
    .ow_if_valid  (bus.ow_if_valid),
    .ow_hold      (bus.ow_hold),
    .ow_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         v;
    logic [W-1:0] pc;
    logic [W-1:0] data;
    logic         stall;
    logic         flush;
    logic         e_valid;
    logic         e_hold;
    logic [W-1:0] e_pc;
    logic [W-1:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  // scoreboard: beats held by the stage, oldest first
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_i_q[$];
  logic [W-1:0] last_pc;
  logic [W-1:0] last_instr;

  function automatic logic [W-1:0] dat(input logic [W-1:0] pc);
    return pc ^ 24'hC35A00;
  endfunction

  task automatic add(input logic r, input logic v, input logic [W-1:0] pc,
                     input logic [W-1:0] data, input logic st, input logic fl,
                     input logic ev, input logic eh, input logic [W-1:0] epc,
                     input logic [W-1:0] ei);
    vec_t t;
    t.rst = r; t.v = v; t.pc = pc; t.data = data; t.stall = st; t.flush = fl;
    t.e_valid = ev; t.e_hold = eh; t.e_pc = epc; t.e_instr = ei;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // driver: apply inputs away from the edge, then sample 1 time unit after it
  task automatic drive_cycle(input logic r, input logic v, input logic [W-1:0] pc,
                             input logic [W-1:0] data, input logic st, input logic fl);
    rst             = r;
    bus.iw_ia_valid = v;
    bus.iw_pc       = pc;
    bus.iw_mem_data = data;
    bus.iw_stall    = st;
    bus.iw_flush    = fl;
    @(posedge clk);
    #1;
  endtask

  // Reference: a two-slot in-order queue. The head is what is shown; hold is
  // "queue full". Shown payload sticks at the last head when the queue empties.
  task automatic model_step(input logic r, input logic v, input logic [W-1:0] pc,
                            input logic [W-1:0] data, input logic st, input logic fl);
    bit full;
    bit take;
    full = (exp_q.size() == 2);
    take = (exp_q.size() > 0) && !st;
    if (r) begin
      exp_q.delete(); exp_i_q.delete();
      last_pc = '0; last_instr = '0;
    end else if (fl) begin
      exp_q.delete(); exp_i_q.delete();
    end else begin
      if (take) begin
        void'(exp_q.pop_front());
        void'(exp_i_q.pop_front());
      end
      if (v && !full) begin
        exp_q.push_back(pc);
        exp_i_q.push_back(data);
      end
    end
    if (exp_q.size() > 0) begin
      last_pc    = exp_q[0];
      last_instr = exp_i_q[0];
    end
  endtask

  initial begin
    logic [W-1:0] cur_pc;
    logic [W-1:0] cur_dat;
    logic         cur_v;
    logic         r, st, fl;
    total = 0;
    bad   = 0;
    last_pc = '0;
    last_instr = '0;
    drive_cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);

    // directed table: inputs for one edge, outputs expected right after it
    add(1, 1, 24'h000055, dat(24'h55), 0, 0,   0, 0, 24'h0, 24'h0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 24'h000100 + W'(i), dat(24'h100 + W'(i)), 0, 0,
          1, 0, 24'h000100 + W'(i), dat(24'h100 + W'(i)));
    add(0, 0, 24'h0, 24'h0, 0, 0,                 0, 0, 24'h104, dat(24'h104));
    add(0, 1, 24'h10, dat(24'h10), 0, 0,          1, 0, 24'h10, dat(24'h10));
    add(0, 1, 24'h11, dat(24'h11), 1, 0,          1, 1, 24'h10, dat(24'h10));
    add(0, 1, 24'h12, dat(24'h12), 1, 0,          1, 1, 24'h10, dat(24'h10));
    add(0, 1, 24'h12, dat(24'h12), 0, 0,          1, 0, 24'h11, dat(24'h11));
    add(0, 1, 24'h12, dat(24'h12), 0, 0,          1, 0, 24'h12, dat(24'h12));
    add(0, 0, 24'h0, 24'h0, 0, 0,                 0, 0, 24'h12, dat(24'h12));
    add(0, 1, 24'h20, dat(24'h20), 1, 0,          1, 0, 24'h20, dat(24'h20));
    add(0, 1, 24'h21, dat(24'h21), 1, 0,          1, 1, 24'h20, dat(24'h20));
    add(0, 1, 24'h22, dat(24'h22), 1, 1,          0, 0, 24'h20, dat(24'h20));
    add(0, 0, 24'h0, 24'h0, 0, 0,                 0, 0, 24'h20, dat(24'h20));
    add(0, 1, 24'h30, dat(24'h30), 1, 0,          1, 0, 24'h30, dat(24'h30));
    add(0, 1, 24'h31, dat(24'h31), 1, 0,          1, 1, 24'h30, dat(24'h30));
    add(1, 1, 24'h32, dat(24'h32), 1, 1,          0, 0, 24'h0, 24'h0);
    add(0, 1, 24'h200, dat(24'h200), 0, 0,        1, 0, 24'h200, dat(24'h200));
    add(0, 0, 24'h0, 24'h0, 0, 0,                 0, 0, 24'h200, dat(24'h200));
    add(0, 1, 24'h3F, 24'h111111, 1, 0,           1, 0, 24'h3F, 24'h111111);
    add(0, 1, 24'h40, 24'hABCDEF, 1, 0,           1, 1, 24'h3F, 24'h111111);
    add(0, 0, 24'h0, 24'h0, 0, 0,                 1, 0, 24'h40, 24'hABCDEF);
    add(0, 0, 24'h0, 24'h0, 0, 0,                 0, 0, 24'h40, 24'hABCDEF);
    add(0, 1, 24'h40, 24'hABCDEF, 0, 0,           1, 0, 24'h40, 24'hABCDEF);
    add(0, 1, 24'h50, dat(24'h50), 0, 1,          0, 0, 24'h40, 24'hABCDEF);

    foreach (vecs[i]) begin
      drive_cycle(vecs[i].rst, vecs[i].v, vecs[i].pc, vecs[i].data,
                  vecs[i].stall, vecs[i].flush);
      chk($sformatf("v%0d_valid", i), W'(bus.ow_if_valid), W'(vecs[i].e_valid));
      chk($sformatf("v%0d_hold", i),  W'(bus.ow_hold),     W'(vecs[i].e_hold));
      chk($sformatf("v%0d_pc", i),    bus.ow_pc,           vecs[i].e_pc);
      chk($sformatf("v%0d_instr", i), bus.ow_instr,        vecs[i].e_instr);
    end

    // random traffic: upstream re-presents its beat while held
    model_step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    cur_pc  = 24'h001000;
    cur_dat = W'($urandom);
    cur_v   = 1'b1;
    for (int c = 0; c < 600; c++) begin
      r  = ($urandom_range(0, 99) == 0);
      st = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 24) == 0);
      model_step(r, cur_v, cur_pc, cur_dat, st, fl);
      drive_cycle(r, cur_v, cur_pc, cur_dat, st, fl);
      chk($sformatf("r%0d_valid", c), W'(bus.ow_if_valid), W'(exp_q.size() > 0));
      chk($sformatf("r%0d_hold", c),  W'(bus.ow_hold),     W'(exp_q.size() == 2));
      chk($sformatf("r%0d_pc", c),    bus.ow_pc,           last_pc);
      chk($sformatf("r%0d_instr", c), bus.ow_instr,        last_instr);
      chk($sformatf("r%0d_state", c), W'(dbg_state),       W'(exp_q.size()));
      // a held beat must be re-presented unchanged; otherwise move on
      if (!(cur_v && bus.ow_hold)) begin
        if (cur_v) cur_pc = cur_pc + 24'd1;
        cur_dat = W'($urandom);
        cur_v   = ($urandom_range(0, 3) != 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
